// File: rtl/usb3_lfps_tx_pkg.sv
// Shared USB3 LFPS constants: state encoding and default timing values
// (125 MHz local clock) used by the LFPS transmitter and its neighbours.
package usb3_lfps_tx_pkg;

  localparam int CNT_W = 24;

  localparam int BURST_POLL_DEF   = 125;
  localparam int REPEAT_POLL_DEF  = 1250;
  localparam int BURST_PING_DEF   = 12;
  localparam int EXIT_MIN_DEF     = 75;
  localparam int EXIT_TIMEOUT_DEF = 250000;
  localparam int RESET_MIN_DEF    = 10000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_BURST,
    ST_POLL_GAP,
    ST_PING,
    ST_EXIT,
    ST_WRESET
  } lfps_state_t;

  // States in which the transmitter drives LFPS rather than electrical idle.
  function automatic logic drives_lfps(lfps_state_t s);
    return (s == ST_POLL_BURST) || (s == ST_PING) || (s == ST_EXIT) || (s == ST_WRESET);
  endfunction

endpackage

// File: rtl/usb3_lfps_tx.sv
// LFPS pattern generator: Polling, Ping, U-exit handshake and Warm Reset,
// timed by a single saturating cycle counter cleared on every state entry.
module usb3_lfps_tx
  import usb3_lfps_tx_pkg::*;
#(
  parameter int BURST_POLL   = BURST_POLL_DEF,
  parameter int REPEAT_POLL  = REPEAT_POLL_DEF,
  parameter int BURST_PING   = BURST_PING_DEF,
  parameter int EXIT_MIN     = EXIT_MIN_DEF,
  parameter int EXIT_TIMEOUT = EXIT_TIMEOUT_DEF,
  parameter int RESET_MIN    = RESET_MIN_DEF
) (
  input  logic local_clk,
  input  logic reset_n,
  input  logic req_poll,
  input  logic req_ping,
  input  logic req_exit,
  input  logic req_reset,
  input  logic partner_lfps,
  output logic tx_elecidle,
  output logic busy,
  output logic poll_burst_done,
  output logic ping_done,
  output logic exit_done,
  output logic exit_timeout,
  output logic reset_done
);

  localparam logic [CNT_W-1:0] POLL_LAST  = CNT_W'(BURST_POLL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(REPEAT_POLL - BURST_POLL - 1);
  localparam logic [CNT_W-1:0] PING_LAST  = CNT_W'(BURST_PING - 1);
  localparam logic [CNT_W-1:0] EXIT_LAST  = CNT_W'(EXIT_MIN - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(EXIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_MIN - 1);

  lfps_state_t      state, next_state;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      tx_elecidle <= 1'b1;
    end else begin
      state       <= next_state;
      tx_elecidle <= !drives_lfps(state);
      if (next_state != state)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    next_state      = state;
    poll_burst_done = 1'b0;
    ping_done       = 1'b0;
    exit_done       = 1'b0;
    exit_timeout    = 1'b0;
    reset_done      = 1'b0;

    // Warm Reset preempts everything; the aborted pattern reports nothing.
    if (req_reset && state != ST_WRESET) begin
      next_state = ST_WRESET;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_exit)      next_state = ST_EXIT;
          else if (req_poll) next_state = ST_POLL_BURST;
          else if (req_ping) next_state = ST_PING;
        end
        ST_POLL_BURST: begin
          if (cnt == POLL_LAST) begin
            poll_burst_done = 1'b1;
            next_state      = ST_POLL_GAP;
          end
        end
        ST_POLL_GAP: begin
          if (!req_poll)            next_state = ST_IDLE;
          else if (cnt == GAP_LAST) next_state = ST_POLL_BURST;
        end
        ST_PING: begin
          if (cnt == PING_LAST) begin
            ping_done  = 1'b1;
            next_state = ST_IDLE;
          end
        end
        ST_EXIT: begin
          if (cnt >= EXIT_LAST && partner_lfps) begin
            exit_done  = 1'b1;
            next_state = ST_IDLE;
          end else if (cnt == TMO_LAST) begin
            exit_timeout = 1'b1;
            next_state   = ST_IDLE;
          end
        end
        ST_WRESET: begin
          if (!req_reset && cnt >= RESET_LAST) begin
            reset_done = 1'b1;
            next_state = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_usb3_lfps_tx.sv
// Self-checking bench for usb3_lfps_tx: directed scenarios with tallies plus
// randomized traffic compared each cycle against a pattern-level model.
module tb_usb3_lfps_tx;

  localparam int BP  = 4;   // BURST_POLL
  localparam int RP  = 10;  // REPEAT_POLL
  localparam int BPG = 2;   // BURST_PING
  localparam int EM  = 3;   // EXIT_MIN
  localparam int ET  = 20;  // EXIT_TIMEOUT
  localparam int RM  = 8;   // RESET_MIN

  logic local_clk = 1'b0;
  logic reset_n   = 1'b0;
  logic req_poll = 1'b0, req_ping = 1'b0, req_exit = 1'b0, req_reset = 1'b0;
  logic partner_lfps = 1'b0;
  logic tx_elecidle, busy, poll_burst_done, ping_done, exit_done, exit_timeout, reset_done;

  usb3_lfps_tx #(
    .BURST_POLL(BP), .REPEAT_POLL(RP), .BURST_PING(BPG),
    .EXIT_MIN(EM), .EXIT_TIMEOUT(ET), .RESET_MIN(RM)
  ) dut (
    .local_clk(local_clk), .reset_n(reset_n),
    .req_poll(req_poll), .req_ping(req_ping), .req_exit(req_exit),
    .req_reset(req_reset), .partner_lfps(partner_lfps),
    .tx_elecidle(tx_elecidle), .busy(busy),
    .poll_burst_done(poll_burst_done), .ping_done(ping_done),
    .exit_done(exit_done), .exit_timeout(exit_timeout), .reset_done(reset_done)
  );

  always #4 local_clk = ~local_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Pattern-level model: polling is one activity whose burst/gap phase is
  // the elapsed time modulo the repeat period.
  localparam int M_IDLE = 0, M_POLL = 1, M_PING = 2, M_EXIT = 3, M_WRST = 4;
  int   m_mode = M_IDLE;
  int   m_age  = 0;
  logic m_idle = 1'b1;

  function automatic logic m_driving();
    if (m_mode == M_POLL) return (m_age % RP) < BP;
    return m_mode != M_IDLE;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_age  = 0;
    m_idle = 1'b1;
  endtask

  task automatic model_step();
    logic nxt_idle;
    nxt_idle = !m_driving();
    if (req_reset && m_mode != M_WRST) begin
      m_mode = M_WRST; m_age = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_age = 0;
          if (req_exit)      m_mode = M_EXIT;
          else if (req_poll) m_mode = M_POLL;
          else if (req_ping) m_mode = M_PING;
        end
        M_POLL: if ((m_age % RP) >= BP && !req_poll) m_mode = M_IDLE; else m_age++;
        M_PING: if (m_age == BPG - 1) m_mode = M_IDLE; else m_age++;
        M_EXIT: if ((m_age >= EM - 1 && partner_lfps) || m_age == ET - 1) m_mode = M_IDLE;
                else m_age++;
        default: if (!req_reset && m_age >= RM - 1) m_mode = M_IDLE; else m_age++;
      endcase
    end
    m_idle = nxt_idle;
  endtask

  int low_cnt, n_pbd, n_ping, n_exit, n_tmo, n_rst;

  task automatic clear_tally();
    low_cnt = 0; n_pbd = 0; n_ping = 0; n_exit = 0; n_tmo = 0; n_rst = 0;
  endtask

  // Called at a falling edge with inputs already applied; compares, tallies,
  // advances one clock and returns at the next falling edge.
  task automatic tick();
    logic prem, e_win;
    #1;
    prem  = req_reset && m_mode != M_WRST;
    e_win = m_mode == M_EXIT && m_age >= EM - 1 && partner_lfps;
    check("tx_elecidle", tx_elecidle, m_idle);
    check("busy", busy, m_mode != M_IDLE);
    check("poll_burst_done", poll_burst_done, !prem && m_mode == M_POLL && (m_age % RP) == BP - 1);
    check("ping_done", ping_done, !prem && m_mode == M_PING && m_age == BPG - 1);
    check("exit_done", exit_done, !prem && e_win);
    check("exit_timeout", exit_timeout, !prem && m_mode == M_EXIT && m_age == ET - 1 && !e_win);
    check("reset_done", reset_done, m_mode == M_WRST && !req_reset && m_age >= RM - 1);
    if (tx_elecidle === 1'b0) low_cnt++;
    if (poll_burst_done === 1'b1) n_pbd++;
    if (ping_done === 1'b1) n_ping++;
    if (exit_done === 1'b1) n_exit++;
    if (exit_timeout === 1'b1) n_tmo++;
    if (reset_done === 1'b1) n_rst++;
    @(posedge local_clk);
    model_step();
    @(negedge local_clk);
  endtask

  task automatic idle_ticks(input int n);
    req_poll = 0; req_ping = 0; req_exit = 0; req_reset = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clear_tally();
    repeat (3) @(negedge local_clk);
    #1;
    check("rst_tx_elecidle", tx_elecidle, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_pulses", {poll_burst_done, ping_done, exit_done, exit_timeout, reset_done}, 5'b0);
    @(negedge local_clk);
    reset_n = 1'b1;
    idle_ticks(3);

    // Polling held for 25 cycles: three bursts, then idle from the third gap.
    clear_tally();
    req_poll = 1;
    for (int i = 0; i < 25; i++) tick();
    idle_ticks(12);
    check("poll_low_cycles", low_cnt, 12);
    check("poll_done_pulses", n_pbd, 3);
    check("poll_ends_idle", busy, 1'b0);

    // Ping, with a second request during the burst dropped.
    clear_tally();
    req_ping = 1; tick();
    req_ping = 1; tick();
    idle_ticks(6);
    check("ping_low_cycles", low_cnt, 2);
    check("ping_done_pulses", n_ping, 1);

    // U-exit answered by the partner from the first EXIT cycle.
    clear_tally();
    req_exit = 1; tick();
    req_exit = 0; partner_lfps = 1;
    for (int i = 0; i < 8; i++) tick();
    partner_lfps = 0;
    check("exit_low_cycles", low_cnt, 3);
    check("exit_done_pulses", n_exit, 1);
    check("exit_no_timeout", n_tmo, 0);

    // U-exit never answered.
    clear_tally();
    req_exit = 1; tick();
    idle_ticks(26);
    check("tmo_low_cycles", low_cnt, 20);
    check("tmo_pulses", n_tmo, 1);
    check("tmo_no_exit_done", n_exit, 0);

    // Warm Reset pulsed for two cycles in the middle of a polling burst.
    clear_tally();
    req_poll = 1; tick(); tick(); tick();
    req_poll = 0; req_reset = 1; tick(); tick();
    idle_ticks(14);
    check("wrst_low_cycles", low_cnt, 11);
    check("wrst_done_pulses", n_rst, 1);
    check("wrst_no_poll_done", n_pbd, 0);

    // Same-cycle exit and ping: only the exit runs.
    clear_tally();
    req_exit = 1; req_ping = 1; tick();
    idle_ticks(25);
    check("arb_no_ping", n_ping, 0);
    check("arb_exit_timeout", n_tmo, 1);
    check("arb_low_cycles", low_cnt, 20);

    // Asynchronous reset in the middle of EXIT.
    clear_tally();
    req_exit = 1; tick();
    req_exit = 0; tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_tx_elecidle", tx_elecidle, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_pulses", {poll_burst_done, ping_done, exit_done, exit_timeout, reset_done}, 5'b0);
    model_reset();
    @(negedge local_clk);
    reset_n = 1'b1;
    clear_tally();
    idle_ticks(25);
    check("arst_no_pulses", n_exit + n_tmo + n_ping + n_pbd + n_rst, 0);
    check("arst_stays_idle", low_cnt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) req_poll = !req_poll;
      if (req_reset) req_reset = ($urandom_range(0, 3) != 0);
      else           req_reset = ($urandom_range(0, 199) == 0);
      req_exit = ($urandom_range(0, 19) == 0);
      req_ping = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 5) == 0) partner_lfps = !partner_lfps;
      tick();
    end
    idle_ticks(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/usb3_lfps_tx.md
USB3_LFPS_TX -- requirements
Module: usb3_lfps_tx

Interface
REQ-001 Parameter BURST_POLL, default 125, Polling.LFPS burst length in local_clk cycles (1.0 us at 125 MHz).
REQ-002 Parameter REPEAT_POLL, default 1250, Polling.LFPS burst-start to burst-start period in cycles (10 us).
REQ-003 Parameter BURST_PING, default 12, Ping.LFPS burst length in cycles (96 ns).
REQ-004 Parameter EXIT_MIN, default 75, minimum U1/U2/U3-exit LFPS duration in cycles (600 ns).
REQ-005 Parameter EXIT_TIMEOUT, default 250000, U-exit no-response timeout in cycles (2 ms).
REQ-006 Parameter RESET_MIN, default 10000000, minimum Warm Reset LFPS duration in cycles (80 ms).
REQ-007 local_clk  in  1  sole clock, 125 MHz; one clock, all logic on its rising edge.
REQ-008 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-009 req_poll  in  1  level; send repeated Polling.LFPS while high.
REQ-010 req_ping  in  1  single-cycle pulse; send one Ping.LFPS.
REQ-011 req_exit  in  1  single-cycle pulse; start U-exit LFPS handshake.
REQ-012 req_reset  in  1  level; send Warm Reset LFPS while high.
REQ-013 partner_lfps  in  1  level from LFPS receiver; partner is driving LFPS.
REQ-014 tx_elecidle  out  1  registered; 0 = LFPS driven on PHY, 1 = electrical idle.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 poll_burst_done, ping_done, exit_done, exit_timeout, reset_done  out  1 each  single-cycle completion pulses.

Function
REQ-017 States SHALL be IDLE, POLL_BURST, POLL_GAP, PING, EXIT, WRESET; one 24-bit cycle counter shared by all states, cleared on every state entry.
REQ-018 tx_elecidle SHALL be 0 exactly in POLL_BURST, PING, EXIT, WRESET, and SHALL change one cycle after the state-changing edge (registered).
REQ-019 Arbitration in IDLE, same-cycle requests: req_reset > req_exit > req_poll > req_ping; losing pulses are dropped.
REQ-020 req_reset high in any state SHALL preempt to WRESET next cycle, with no completion pulse for the aborted pattern.
REQ-021 req_exit, req_ping, and rising req_poll while busy (not IDLE) SHALL be ignored.
REQ-022 POLL_BURST SHALL last BURST_POLL cycles, pulse poll_burst_done on its last cycle, then enter POLL_GAP.
REQ-023 POLL_GAP SHALL last REPEAT_POLL-BURST_POLL cycles, then return to POLL_BURST if req_poll is high, else IDLE.
REQ-024 req_poll falling during POLL_BURST SHALL NOT truncate the burst; falling during POLL_GAP SHALL go to IDLE next cycle.
REQ-025 PING SHALL last BURST_PING cycles, pulsing ping_done on the last cycle, then go to IDLE.
REQ-026 EXIT SHALL end on the first cycle where counter >= EXIT_MIN-1 and partner_lfps=1, pulsing exit_done.
REQ-027 EXIT SHALL end when the counter reaches EXIT_TIMEOUT-1 without that condition, pulsing exit_timeout.
REQ-028 If the exit and timeout conditions coincide, exit_done SHALL win and exit_timeout SHALL stay 0.
REQ-029 WRESET SHALL persist while req_reset is high, and for at least RESET_MIN cycles from entry.
REQ-030 On leaving WRESET, the block SHALL pulse reset_done and go to IDLE; the counter SHALL saturate and never wrap.

Reset
REQ-031 reset_n low SHALL force IDLE, counter 0, tx_elecidle 1, busy 0, and all pulses 0, asynchronously.
REQ-032 Reset mid-burst SHALL raise tx_elecidle immediately; after release, no request captured before reset is honoured.

Structure
REQ-033 State encodings and default timing constants SHALL live in the shared USB3 constants include used by the LTSSM and LFPS receiver.
REQ-034 No sub-module is required; the counter SHALL be inline.

Verification (BURST_POLL=4, REPEAT_POLL=10, BURST_PING=2, EXIT_MIN=3, EXIT_TIMEOUT=20, RESET_MIN=8)
REQ-035 req_poll high for 25 cycles -> tx_elecidle low 4 of every 10 cycles, 3 poll_burst_done pulses, idle after the third gap edge.
REQ-036 req_ping pulse -> tx_elecidle low exactly 2 cycles, then one ping_done; a second req_ping during the burst -> dropped.
REQ-037 req_exit with partner_lfps high from cycle 1 -> exit_done at counter 2 (3 cycles low); partner_lfps never -> exit_timeout after 20 cycles low.
REQ-038 req_reset pulsed high 2 cycles during POLL_BURST -> WRESET next cycle, 8 cycles low, reset_done, no poll_burst_done.
REQ-039 Same-cycle req_exit+req_ping -> EXIT only.
REQ-040 reset_n low mid-EXIT -> tx_elecidle 1 in the same cycle, no pulses.
